if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Holds the PC, drives the instruction
//                memory address combinationally from it, and captures the
//                fetched word into the IF/ID pipeline register. A two-state
//                fetch FSM (RUN/HALT) parks fetch after ECALL/EBREAK until a
//                redirect arrives.
//  Ports       :
//    clk          in   1   clock, rising-edge active
//    reset        in   1   synchronous active-high reset
//    stall        in   1   freeze PC and IF/ID register (ignored in HALT)
//    redirect     in   1   taken branch/jump: flush IF/ID, load redirect_pc
//    redirect_pc  in   32  redirect target
//    imem_addr    out  32  instruction memory address (= PC register)
//    imem_rdata   in   32  instruction word at imem_addr, same cycle
//    id_instr     out  32  IF/ID instruction (NOP_INSTR when a bubble)
//    id_pc        out  32  IF/ID PC of id_instr
//    id_valid     out  1   id_instr is a real fetched instruction
//    halted       out  1   fetch FSM is in HALT
//    misalign_err out  1   sticky: a redirect target had nonzero bits [1:0]
//    fetch_count  out  32  instructions accepted into IF/ID (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [0:0]  c_ST_RUN  = 1'b0;
    localparam logic [0:0]  c_ST_HALT = 1'b1;
    localparam logic [31:0] c_ECALL   = 32'h0000_0073;
    localparam logic [31:0] c_EBREAK  = 32'h0010_0073;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic        r_id_valid;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    logic        w_is_system;

    assign w_is_system = (imem_rdata == c_ECALL) || (imem_rdata == c_EBREAK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_RUN;
            r_pc          <= RESET_PC;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= 32'h0000_0000;
            r_id_valid    <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 32'h0000_0000;
        end else if (redirect) begin
            // Target is force-aligned; a misaligned request is only flagged.
            r_state    <= c_ST_RUN;
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
        end else if (r_state == c_ST_HALT) begin
            // Parked: keep issuing bubbles at a frozen PC, stall has no effect.
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (!stall) begin
            r_id_instr    <= imem_rdata;
            r_id_pc       <= r_pc;
            r_id_valid    <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
            // ECALL/EBREAK is still delivered to decode, but the PC stays on
            // it so fetch resumes only via redirect.
            if (w_is_system) begin
                r_state <= c_ST_HALT;
            end else begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign id_instr     = r_id_instr;
    assign id_pc        = r_id_pc;
    assign id_valid     = r_id_valid;
    assign halted       = (r_state == c_ST_HALT);
    assign misalign_err = r_misalign;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Self-checking bench for if_stage. A table of per-edge input
//                records with hand-computed expected outputs, followed by
//                hand-written sequences for sticky misalign and the
//                combinational-address property.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halt;
        logic        e_mis;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int c_NVEC = 21;
    vec_t vecs [c_NVEC];

    function automatic vec_t mk(
        input logic rst, input logic stl, input logic rdr,
        input logic [31:0] rpc, input logic [31:0] rdata,
        input logic [31:0] e_addr, input logic [31:0] e_instr,
        input logic [31:0] e_pc, input logic e_valid, input logic e_halt,
        input logic e_mis, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.rdata = rdata;
        v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_halt = e_halt; v.e_mis = e_mis;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rdr,
                         input logic [31:0] rpc, input logic [31:0] rdata);
        @(negedge clk);
        reset       = rst;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_rdata  = rdata;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_rdata = 32'h13;

        //            rst  stl  rdr  rpc            rdata          addr           instr          id_pc          v    h    mis  cnt
        vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0,         32'h0,         32'h0,         32'h13,        32'h0,         1'b0,1'b0,1'b0,32'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,         32'h11,        32'h4,         32'h11,        32'h0,         1'b1,1'b0,1'b0,32'd1);
        vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,         32'h22,        32'h8,         32'h22,        32'h4,         1'b1,1'b0,1'b0,32'd2);
        vecs[3]  = mk(1'b0,1'b1,1'b0,32'h0,         32'h33,        32'h8,         32'h22,        32'h4,         1'b1,1'b0,1'b0,32'd2);
        vecs[4]  = mk(1'b0,1'b1,1'b0,32'h0,         32'h33,        32'h8,         32'h22,        32'h4,         1'b1,1'b0,1'b0,32'd2);
        vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,         32'h33,        32'hC,         32'h33,        32'h8,         1'b1,1'b0,1'b0,32'd3);
        vecs[6]  = mk(1'b0,1'b1,1'b1,32'h100,       32'h44,        32'h100,       32'h13,        32'h8,         1'b0,1'b0,1'b0,32'd3);
        vecs[7]  = mk(1'b0,1'b0,1'b0,32'h0,         32'h55,        32'h104,       32'h55,        32'h100,       1'b1,1'b0,1'b0,32'd4);
        vecs[8]  = mk(1'b0,1'b0,1'b1,32'h203,       32'hAA,        32'h200,       32'h13,        32'h100,       1'b0,1'b0,1'b1,32'd4);
        vecs[9]  = mk(1'b0,1'b0,1'b1,32'h10,        32'hAA,        32'h10,        32'h13,        32'h100,       1'b0,1'b0,1'b1,32'd4);
        vecs[10] = mk(1'b0,1'b0,1'b0,32'h0,         32'h73,        32'h10,        32'h73,        32'h10,        1'b1,1'b1,1'b1,32'd5);
        vecs[11] = mk(1'b0,1'b1,1'b0,32'h0,         32'h73,        32'h10,        32'h13,        32'h10,        1'b0,1'b1,1'b1,32'd5);
        vecs[12] = mk(1'b0,1'b0,1'b0,32'h0,         32'h99,        32'h10,        32'h13,        32'h10,        1'b0,1'b1,1'b1,32'd5);
        vecs[13] = mk(1'b0,1'b0,1'b1,32'h40,        32'h73,        32'h40,        32'h13,        32'h10,        1'b0,1'b0,1'b1,32'd5);
        vecs[14] = mk(1'b0,1'b0,1'b0,32'h0,         32'h66,        32'h44,        32'h66,        32'h40,        1'b1,1'b0,1'b1,32'd6);
        vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,         32'h0010_0073, 32'h44,        32'h0010_0073, 32'h44,        1'b1,1'b1,1'b1,32'd7);
        vecs[16] = mk(1'b1,1'b0,1'b1,32'h203,       32'h11,        32'h0,         32'h13,        32'h0,         1'b0,1'b0,1'b0,32'd0);
        vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,         32'h77,        32'h4,         32'h77,        32'h0,         1'b1,1'b0,1'b0,32'd1);
        vecs[18] = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC, 32'h11,        32'hFFFF_FFFC, 32'h13,        32'h0,         1'b0,1'b0,1'b0,32'd1);
        vecs[19] = mk(1'b0,1'b0,1'b0,32'h0,         32'h88,        32'h0,         32'h88,        32'hFFFF_FFFC, 1'b1,1'b0,1'b0,32'd2);
        vecs[20] = mk(1'b1,1'b1,1'b0,32'h0,         32'h11,        32'h0,         32'h13,        32'h0,         1'b0,1'b0,1'b0,32'd0);

        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc, vecs[i].rdata);
            @(posedge clk);
            #1;
            check32($sformatf("v%0d imem_addr", i),   imem_addr,    vecs[i].e_addr);
            check32($sformatf("v%0d id_instr", i),    id_instr,     vecs[i].e_instr);
            check32($sformatf("v%0d id_pc", i),       id_pc,        vecs[i].e_pc);
            check1 ($sformatf("v%0d id_valid", i),    id_valid,     vecs[i].e_valid);
            check1 ($sformatf("v%0d halted", i),      halted,       vecs[i].e_halt);
            check1 ($sformatf("v%0d misalign_err", i), misalign_err, vecs[i].e_mis);
            check32($sformatf("v%0d fetch_count", i), fetch_count,  vecs[i].e_cnt);
        end

        // imem_addr must follow the PC register, not redirect_pc, while a
        // redirect is pending before its edge. PC is 0 after vector 20.
        drive(1'b0, 1'b0, 1'b1, 32'h203, 32'h11);
        #1;
        check32("pre-edge imem_addr ignores redirect_pc", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        check32("misaligned redirect addr", imem_addr, 32'h200);
        check1 ("misaligned redirect flag", misalign_err, 1'b1);

        // Sticky across ten free-run cycles; PC advances from 0x200.
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h11);
            @(posedge clk);
            #1;
            check1($sformatf("misalign sticky cycle %0d", k), misalign_err, 1'b1);
        end
        check32("addr after ten advances", imem_addr, 32'h228);
        check32("count after ten advances", fetch_count, 32'd10);

        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h11);
        @(posedge clk);
        #1;
        check1("misalign cleared by reset", misalign_err, 1'b0);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h11);
        #1;
        check32("first addr after reset release", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
